video_mem_arb: RTL and testbench

Arbiter/scheduler sharing one 128-bit video memory request port between `NREQ` display requesters (frame buffer, sprite, cursor, ...). It sits between the requesters and the memory side, which is either the real memory controller or the test pattern generator. It re-tags each accepted request with an internal transaction tag and bounds the number of outstanding reads. It routes variable-latency, possibly out-of-order responses back to the originating requester with the original `tid` restored.

---
 rtl/video_mem_arb.sv | 182 ++++++++++++++++++
 tb/tb_video_mem_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mem_arb.sv
// video_mem_arb: shares one 128-bit video memory request port between NREQ
// display requesters. Accepted requests are re-tagged with an internal tag.
// Out-of-order responses are routed back to their requester with the
// original tid restored.

package video_mem_arb_pkg;

    typedef struct packed {
        logic [5:0]   cid;
        logic [7:0]   tid;
        logic         cyc;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  padr;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic [5:0]   cid;
        logic [7:0]   tid;
        logic         ack;
        logic         stall;
        logic         next;
        logic         rty;
        logic         err;
        logic [2:0]   pri;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

module video_mem_arb
    import video_mem_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int MAX_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 urgent,
    input  fta_cmd_request128_t  req_i  [NREQ],
    output fta_cmd_response128_t resp_o [NREQ],
    output fta_cmd_request128_t  mreq,
    input  fta_cmd_response128_t mresp,
    output logic [7:0]           drop_cnt
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(MAX_OUT);

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        cand_idx;
    logic                 sel_vld;
    logic                 urgent_grant;
    logic [MAX_OUT-1:0]   tag_vld;
    logic [IW-1:0]        tag_req [MAX_OUT];
    logic [7:0]           tag_tid [MAX_OUT];
    logic [TW-1:0]        free_tag;
    logic                 free_vld;
    logic                 accept;
    logic [TW-1:0]        ret_tag;
    logic                 ret_hit;
    fta_cmd_response128_t resp_q [NREQ];

    // Pick one requester: urgent frame buffer first, else round-robin from rr_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_vld      = 1'b0;
        sel_idx      = '0;
        urgent_grant = 1'b0;
        cand_idx     = '0;
        if (urgent && req_i[0].cyc) begin
            sel_vld      = 1'b1;
            urgent_grant = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cand_idx = IW'((int'(rr_ptr) + i) % NREQ);
                if (!sel_vld && req_i[cand_idx].cyc) begin
                    sel_vld = 1'b1;
                    sel_idx = cand_idx;
                end
            end
        end
    end

    // Lowest-numbered free tag; sees only last cycle's frees, so a tag
    // released this cycle is not reused until the next one.
    always_comb begin
        free_vld = 1'b0;
        free_tag = '0;
        for (int t = 0; t < MAX_OUT; t++) begin
            if (!free_vld && !tag_vld[t]) begin
                free_vld = 1'b1;
                free_tag = TW'(t);
            end
        end
    end

    assign accept  = sel_vld && !mresp.stall && free_vld;
    assign ret_tag = mresp.tid[TW-1:0];
    assign ret_hit = mresp.ack && (mresp.tid < 8'(MAX_OUT)) && tag_vld[ret_tag];

    // Registered response fields plus a combinational stall for every unaccepted request.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            resp_o[k]       = resp_q[k];
            resp_o[k].stall = req_i[k].cyc && !(accept && (sel_idx == IW'(k)));
        end
    end

    // Round-robin pointer: next start position, held across urgent grants.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!rst) begin
            rr_ptr <= '0;
        end else if (accept && !urgent_grant) begin
            rr_ptr <= (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    // Tag valid bits: set on allocation, cleared on a matching response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
        end else begin
            if (accept)  tag_vld[free_tag] <= 1'b1;
            if (ret_hit) tag_vld[ret_tag]  <= 1'b0;
        end
    end

    // Tag payload: owning requester and original tid, captured at allocation.
    // NOTE: payload is qualified by tag_vld, so this storage needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_req[free_tag] <= sel_idx;
            tag_tid[free_tag] <= req_i[sel_idx].tid;
        end
    end

    // Memory-side command: registered copy of the accepted request with tid replaced by the tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mreq <= '0;
        end else if (accept) begin
            mreq     <= req_i[sel_idx];
            mreq.tid <= 8'(free_tag);
        end else begin
            mreq <= '0;
        end
    end

    // Response routing: one registered ack to the tag's owner, tid restored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) resp_q[k] <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                resp_q[k]     <= '0;
                resp_q[k].pri <= 3'd7;
            end
            if (ret_hit) begin
                resp_q[tag_req[ret_tag]].ack <= 1'b1;
                resp_q[tag_req[ret_tag]].tid <= tag_tid[ret_tag];
                resp_q[tag_req[ret_tag]].cid <= mresp.cid;
                resp_q[tag_req[ret_tag]].adr <= mresp.adr;
                resp_q[tag_req[ret_tag]].dat <= mresp.dat;
            end
        end
    end

    // Saturating count of acks that match no outstanding tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (mresp.ack && !ret_hit && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_mem_arb.sv
// Directed bench for video_mem_arb (NREQ=3, MAX_OUT=8).
// Inputs change on the falling edge; registered outputs are sampled 1ns
// after the rising edge, and stall is sampled 1ns after the inputs change.

module tb_video_mem_arb;
    import video_mem_arb_pkg::*;

    localparam int NREQ    = 3;
    localparam int MAX_OUT = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 urgent;
    fta_cmd_request128_t  req_i  [NREQ];
    fta_cmd_response128_t resp_o [NREQ];
    fta_cmd_request128_t  mreq;
    fta_cmd_response128_t mresp;
    logic [7:0]           drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    video_mem_arb #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .urgent   (urgent),
        .req_i    (req_i),
        .resp_o   (resp_o),
        .mreq     (mreq),
        .mresp    (mresp),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        urgent = 1'b0;
        for (int k = 0; k < NREQ; k++) req_i[k] = '0;
        mresp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Instant memory: ack whatever tag was issued last cycle.
    task automatic echo_ack();
        mresp = '0;
        if (mreq.cyc) begin
            mresp.ack = 1'b1;
            mresp.tid = mreq.tid;
        end
    endtask

    int grant_tbl [9] = '{1, 2, 0, 0, 0, 0, 0, 1, 2};
    logic urg_tbl [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    logic r0_tbl  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        clear_inputs();

        // ---- Reset state ----
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mreq", 200'(mreq), 200'(0));
        for (int k = 0; k < NREQ; k++) check($sformatf("rst_resp%0d", k), 200'(resp_o[k]), 200'(0));
        check("rst_drop", 200'(drop_cnt), 200'(0));
        rst = 1'b1;

        // ---- Single request ----
        @(negedge clk);
        req_i[1].cyc  = 1'b1;
        req_i[1].padr = 32'h1000;
        req_i[1].tid  = 8'h25;
        req_i[1].cid  = 6'd3;
        #1;
        check("single_stall1", 200'(resp_o[1].stall), 200'(0));
        check("single_stall0", 200'(resp_o[0].stall), 200'(0));
        @(posedge clk); #1;
        check("single_mreq_cyc", 200'(mreq.cyc), 200'(1));
        check("single_mreq_tid", 200'(mreq.tid), 200'(0));
        check("single_mreq_padr", 200'(mreq.padr), 200'(32'h1000));
        check("single_mreq_cid", 200'(mreq.cid), 200'(3));
        @(negedge clk);
        req_i[1]  = '0;
        mresp.ack = 1'b1;
        mresp.tid = 8'h00;
        mresp.dat = {16{8'hA5}};
        mresp.adr = 32'h1000;
        mresp.cid = 6'd3;
        @(posedge clk); #1;
        check("single_mreq_idle", 200'(mreq.cyc), 200'(0));
        check("single_ack1", 200'(resp_o[1].ack), 200'(1));
        check("single_tid1", 200'(resp_o[1].tid), 200'(8'h25));
        check("single_dat1", 200'(resp_o[1].dat), 200'({16{8'hA5}}));
        check("single_cid1", 200'(resp_o[1].cid), 200'(3));
        check("single_pri1", 200'(resp_o[1].pri), 200'(7));
        check("single_ack0", 200'(resp_o[0].ack), 200'(0));
        check("single_ack2", 200'(resp_o[2].ack), 200'(0));
        @(negedge clk);
        mresp = '0;
        @(posedge clk); #1;
        check("single_ack1_clear", 200'(resp_o[1].ack), 200'(0));

        // ---- Round-robin fairness ----
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                req_i[k].cyc  = 1'b1;
                req_i[k].tid  = 8'(k);
                req_i[k].padr = 32'(k * 'h100);
            end
            echo_ack();
            #1;
            for (int k = 0; k < NREQ; k++)
                check($sformatf("rr_stall%0d_c%0d", k, i), 200'(resp_o[k].stall), 200'(k != (i % 3)));
            @(posedge clk); #1;
            check($sformatf("rr_grant_c%0d", i), 200'(mreq.padr), 200'(32'((i % 3) * 'h100)));
            if (i > 0) begin
                check($sformatf("rr_ret_ack_c%0d", i), 200'(resp_o[(i - 1) % 3].ack), 200'(1));
                check($sformatf("rr_ret_tid_c%0d", i), 200'(resp_o[(i - 1) % 3].tid), 200'((i - 1) % 3));
            end
        end
        @(negedge clk);
        for (int k = 0; k < NREQ; k++) req_i[k] = '0;
        echo_ack();
        @(negedge clk);
        mresp = '0;

        // ---- Urgent priority (pointer is 0 here) ----
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                req_i[k].cyc  = (k == 0) ? r0_tbl[i] : 1'b1;
                req_i[k].padr = 32'(k * 'h100);
            end
            urgent = urg_tbl[i];
            echo_ack();
            #1;
            for (int k = 0; k < NREQ; k++)
                check($sformatf("urg_stall%0d_c%0d", k, i), 200'(resp_o[k].stall),
                      200'(req_i[k].cyc && (k != grant_tbl[i])));
            @(posedge clk); #1;
            check($sformatf("urg_grant_c%0d", i), 200'(mreq.padr), 200'(32'(grant_tbl[i] * 'h100)));
        end
        @(negedge clk);
        clear_inputs();
        echo_ack();
        @(negedge clk);
        mresp = '0;

        // ---- Credit limit and out-of-order return ----
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                req_i[k].cyc  = 1'b1;
                req_i[k].tid  = 8'(8'h40 + c);
                req_i[k].padr = 32'(k * 'h100);
            end
            #1;
            if (c >= MAX_OUT) begin
                for (int k = 0; k < NREQ; k++)
                    check($sformatf("full_stall%0d_c%0d", k, c), 200'(resp_o[k].stall), 200'(1));
            end
            @(posedge clk); #1;
            if (c < MAX_OUT) begin
                check($sformatf("credit_tag_c%0d", c), 200'(mreq.tid), 200'(c));
                check($sformatf("credit_grant_c%0d", c), 200'(mreq.padr), 200'(32'((c % 3) * 'h100)));
            end else begin
                check($sformatf("full_idle_c%0d", c), 200'(mreq.cyc), 200'(0));
            end
        end
        @(negedge clk);
        mresp.ack = 1'b1;
        mresp.tid = 8'd5;
        #1;
        for (int k = 0; k < NREQ; k++)
            check($sformatf("full_free_stall%0d", k), 200'(resp_o[k].stall), 200'(1));
        @(posedge clk); #1;
        check("ooo5_ack", 200'(resp_o[2].ack), 200'(1));
        check("ooo5_tid", 200'(resp_o[2].tid), 200'(8'h45));
        check("ooo5_noissue", 200'(mreq.cyc), 200'(0));
        @(negedge clk);
        for (int k = 0; k < NREQ; k++) req_i[k] = '0;
        mresp.tid = 8'd2;
        @(posedge clk); #1;
        check("ooo2_ack", 200'(resp_o[2].ack), 200'(1));
        check("ooo2_tid", 200'(resp_o[2].tid), 200'(8'h42));
        @(negedge clk);
        mresp.tid = 8'd7;
        @(posedge clk); #1;
        check("ooo7_ack", 200'(resp_o[1].ack), 200'(1));
        check("ooo7_tid", 200'(resp_o[1].tid), 200'(8'h47));
        check("ooo7_other", 200'(resp_o[2].ack), 200'(0));
        @(negedge clk);
        mresp = '0;
        req_i[0].cyc = 1'b1;
        req_i[0].tid = 8'h77;
        #1;
        check("realloc_stall0", 200'(resp_o[0].stall), 200'(0));
        @(posedge clk); #1;
        check("realloc_cyc", 200'(mreq.cyc), 200'(1));
        check("realloc_tag", 200'(mreq.tid), 200'(2));

        // ---- Unknown tag and saturation ----
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            mresp.ack = 1'b1;
            mresp.tid = 8'd3;
            @(posedge clk); #1;
            if (n == 1) begin
                for (int k = 0; k < NREQ; k++)
                    check($sformatf("unk_ack%0d", k), 200'(resp_o[k].ack), 200'(0));
                check("unk_drop1", 200'(drop_cnt), 200'(1));
            end
            if (n == 254 || n == 255) check($sformatf("unk_drop%0d", n), 200'(drop_cnt), 200'(n));
            if (n == 300) check("unk_drop_sat", 200'(drop_cnt), 200'(255));
        end
        @(negedge clk);
        mresp = '0;

        // ---- Reset mid-flight ----
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_i[0].cyc = 1'b1;
            req_i[0].tid = 8'(8'h60 + c);
            @(posedge clk); #1;
            check($sformatf("mid_tag_c%0d", c), 200'(mreq.tid), 200'(c));
        end
        @(negedge clk);
        req_i[0] = '0;
        rst = 1'b0;
        #1;
        check("mid_rst_mreq", 200'(mreq), 200'(0));
        for (int k = 0; k < NREQ; k++) check($sformatf("mid_rst_resp%0d", k), 200'(resp_o[k]), 200'(0));
        check("mid_rst_drop", 200'(drop_cnt), 200'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            mresp.ack = 1'b1;
            mresp.tid = 8'(t);
            @(posedge clk); #1;
            check($sformatf("mid_stale_ack_t%0d", t), 200'(resp_o[0].ack), 200'(0));
        end
        check("mid_drop4", 200'(drop_cnt), 200'(4));
        @(negedge clk);
        mresp = '0;
        req_i[0].cyc = 1'b1;
        req_i[0].tid = 8'h99;
        @(posedge clk); #1;
        check("mid_new_cyc", 200'(mreq.cyc), 200'(1));
        check("mid_new_tag", 200'(mreq.tid), 200'(0));
        @(negedge clk);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
